// File: rtl/addernet_operand_packer_if.sv
// Bundle for the AdderNet operand packer: the narrow (feature, weight) pair stream in,
// and the packed lane vector out. The i_last signal exists only when PACKER_FLUSH_EN is defined.
interface addernet_operand_packer_if #(
    parameter int NBIT  = 16,
    parameter int NDATA = 64,
    parameter int CNTW  = 7
);
    logic                  i_vld;
    logic                  o_rdy;
    logic [NBIT-1:0]       i_if;
    logic [NBIT-1:0]       i_w;
`ifdef PACKER_FLUSH_EN
    logic                  i_last;
`endif
    logic                  o_vld;
    logic                  i_rdy;
    logic [NBIT*NDATA-1:0] o_if;
    logic [NBIT*NDATA-1:0] o_w;
    logic [CNTW-1:0]       o_lanes;

`ifdef PACKER_FLUSH_EN
    modport slave (
        input  i_vld, i_if, i_w, i_last, i_rdy,
        output o_rdy, o_vld, o_if, o_w, o_lanes
    );
    modport master (
        output i_vld, i_if, i_w, i_last, i_rdy,
        input  o_rdy, o_vld, o_if, o_w, o_lanes
    );
`else
    modport slave (
        input  i_vld, i_if, i_w, i_rdy,
        output o_rdy, o_vld, o_if, o_w, o_lanes
    );
    modport master (
        output i_vld, i_if, i_w, i_rdy,
        input  o_rdy, o_vld, o_if, o_w, o_lanes
    );
`endif
endinterface

// File: rtl/addernet_operand_packer.sv
// Double-buffered packer: fills a collect buffer lane by lane from the pair stream and hands
// full vectors to a held output register. Define PACKER_FLUSH_EN to allow i_last to close partial vectors.
module addernet_operand_packer #(
    parameter int NBIT  = 16,
    parameter int NDATA = 64,
    parameter int CNTW  = 7
) (
    input  logic                    CLK,
    input  logic                    RST,
    addernet_operand_packer_if.slave bus
);
    localparam int VW = NBIT * NDATA;

    logic [VW-1:0]   col_if;
    logic [VW-1:0]   col_w;
    logic [CNTW-1:0] cnt;
    logic            col_full;
    logic            accept;
    logic            transfer;
    logic            last_lane;

    // NOTE: o_rdy depends only on registered state, so it never forms a path from i_rdy.
    assign bus.o_rdy = !col_full;
    assign accept    = bus.i_vld && !col_full;
    assign transfer  = col_full && (!bus.o_vld || bus.i_rdy);

`ifdef PACKER_FLUSH_EN
    assign last_lane = (cnt == CNTW'(NDATA - 1)) || bus.i_last;
`else
    assign last_lane = (cnt == CNTW'(NDATA - 1));
`endif

    // Accept and transfer are mutually exclusive: accept needs an open buffer, transfer a full one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the lane buffers are reset on purpose, so that empty lanes always read as zero.
            col_if      <= '0;
            col_w       <= '0;
            cnt         <= '0;
            col_full    <= 1'b0;
            bus.o_vld   <= 1'b0;
            bus.o_if    <= '0;
            bus.o_w     <= '0;
            bus.o_lanes <= '0;
        end else if (transfer) begin
            bus.o_if    <= col_if;
            bus.o_w     <= col_w;
            bus.o_lanes <= cnt;
            bus.o_vld   <= 1'b1;
            col_if      <= '0;
            col_w       <= '0;
            cnt         <= '0;
            col_full    <= 1'b0;
        end else begin
            if (bus.o_vld && bus.i_rdy) begin
                bus.o_vld <= 1'b0;
            end
            if (accept) begin
                for (int k = 0; k < NDATA; k++) begin
                    if (cnt == CNTW'(k)) begin
                        col_if[k*NBIT +: NBIT] <= bus.i_if;
                        col_w[k*NBIT +: NBIT]  <= bus.i_w;
                    end
                end
                cnt      <= cnt + 1'b1;
                col_full <= last_lane;
            end
        end
    end
endmodule

// File: tb/tb_addernet_operand_packer.sv
// Directed bench for addernet_operand_packer: full fill, idle gaps, backpressure with seamless
// hand-over, reset mid-hold/mid-fill, and (with PACKER_FLUSH_EN) a partial-vector flush.
module tb_addernet_operand_packer;
    localparam int NBIT  = 16;
    localparam int NDATA = 64;
    localparam int CNTW  = 7;
    localparam int VW    = NBIT * NDATA;

    typedef struct {
        logic [VW-1:0]   vif;
        logic [VW-1:0]   vw;
        logic [CNTW-1:0] lanes;
    } vec_t;

    logic CLK = 1'b0;
    logic RST;
    int   errors = 0;
    int   checks = 0;
    vec_t cap_q[$];

    always #5 CLK = ~CLK;

    addernet_operand_packer_if #(.NBIT(NBIT), .NDATA(NDATA), .CNTW(CNTW)) bus ();

    addernet_operand_packer #(.NBIT(NBIT), .NDATA(NDATA), .CNTW(CNTW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Record every consumed vector, sampled mid-way between negedge and the next posedge.
    always @(negedge CLK) begin
        vec_t v;
        #3;
        if (bus.o_vld && bus.i_rdy) begin
            v.vif   = bus.o_if;
            v.vw    = bus.o_w;
            v.lanes = bus.o_lanes;
            cap_q.push_back(v);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compares a whole packed vector; a mismatch reports the first differing lane.
    task automatic check_vec(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        int bad = 0;
        for (int k = NDATA - 1; k >= 0; k--) begin
            if (got[k*NBIT +: NBIT] !== exp[k*NBIT +: NBIT]) bad = k;
        end
        check($sformatf("%s lane%0d", tag, bad), 32'(got[bad*NBIT +: NBIT]), 32'(exp[bad*NBIT +: NBIT]));
    endtask

    function automatic logic [NBIT-1:0] pat_if(input int kind, input int k);
        case (kind)
            0:       return NBIT'(k);
            1:       return NBIT'(k + 100);
            2:       return NBIT'(-k);
            default: return 16'h8000 | NBIT'(k);
        endcase
    endfunction

    function automatic logic [NBIT-1:0] pat_w(input int kind, input int k);
        case (kind)
            0:       return NBIT'(k + 1);
            1:       return NBIT'(3 * k);
            2:       return NBIT'(k ^ 5);
            default: return NBIT'(32'h7ff0 + k);
        endcase
    endfunction

    function automatic logic [VW-1:0] build(input int kind, input bit is_w);
        logic [VW-1:0] v = '0;
        for (int k = 0; k < NDATA; k++) begin
            v[k*NBIT +: NBIT] = is_w ? pat_w(kind, k) : pat_if(kind, k);
        end
        return v;
    endfunction

    // Called at a negedge; returns at the negedge right after the pair was accepted.
    task automatic push(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b, input logic last);
        int g = 0;
        bus.i_vld = 1'b1;
        bus.i_if  = a;
        bus.i_w   = b;
`ifdef PACKER_FLUSH_EN
        bus.i_last = last;
`endif
        while (!bus.o_rdy && g < 300) begin
            @(negedge CLK);
            g++;
        end
        if (!bus.o_rdy) check("push_timeout o_rdy", 32'(bus.o_rdy), 32'd1);
        @(negedge CLK);
        bus.i_vld = 1'b0;
`ifdef PACKER_FLUSH_EN
        bus.i_last = 1'b0;
`endif
        if (last === 1'bx) $display("unexpected X on last");
    endtask

    task automatic fill(input int kind, input int npairs, input bit gaps);
        for (int k = 0; k < npairs; k++) begin
            push(pat_if(kind, k), pat_w(kind, k), 1'b0);
            if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
        end
    endtask

    task automatic wait_caps(input int n);
        int g = 0;
        while (cap_q.size() < n && g < 500) begin
            @(negedge CLK);
            g++;
        end
        check("capture_count", 32'(cap_q.size()), 32'(n));
    endtask

    task automatic check_idle(input string tag);
        check({tag, " o_vld"}, 32'(bus.o_vld), 32'd0);
        check({tag, " o_rdy"}, 32'(bus.o_rdy), 32'd1);
        check({tag, " o_lanes"}, 32'(bus.o_lanes), 32'd0);
        check_vec({tag, " o_if"}, bus.o_if, '0);
        check_vec({tag, " o_w"}, bus.o_w, '0);
    endtask

    initial begin
        bus.i_vld = 1'b0;
        bus.i_if  = '0;
        bus.i_w   = '0;
        bus.i_rdy = 1'b0;
`ifdef PACKER_FLUSH_EN
        bus.i_last = 1'b0;
`endif
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check_idle("reset");

        // Full fill with the output free: o_vld one cycle after the 64th accept.
        bus.i_rdy = 1'b1;
        fill(0, NDATA, 1'b0);
        check("full o_rdy", 32'(bus.o_rdy), 32'd0);
        check("full o_vld_early", 32'(bus.o_vld), 32'd0);
        @(negedge CLK);
        check("full o_vld", 32'(bus.o_vld), 32'd1);
        check("full o_rdy_back", 32'(bus.o_rdy), 32'd1);
        check("full o_lanes", 32'(bus.o_lanes), 32'(NDATA));
        check_vec("full o_if", bus.o_if, build(0, 1'b0));
        check_vec("full o_w", bus.o_w, build(0, 1'b1));
        @(negedge CLK);
        check("full consumed", 32'(bus.o_vld), 32'd0);
        wait_caps(1);
        cap_q.delete();

        // Same vector with idle gaps in i_vld.
        fill(0, NDATA, 1'b1);
        wait_caps(1);
        if (cap_q.size() > 0) begin
            check("gaps o_lanes", 32'(cap_q[0].lanes), 32'(NDATA));
            check_vec("gaps o_if", cap_q[0].vif, build(0, 1'b0));
            check_vec("gaps o_w", cap_q[0].vw, build(0, 1'b1));
        end
        cap_q.delete();

        // Backpressure: two vectors streamed against a stalled core.
        bus.i_rdy = 1'b0;
        fill(1, NDATA, 1'b0);
        fill(2, NDATA, 1'b0);
        check("bp o_rdy", 32'(bus.o_rdy), 32'd0);
        check("bp o_vld", 32'(bus.o_vld), 32'd1);
        check_vec("bp held o_if", bus.o_if, build(1, 1'b0));
        repeat (4) @(negedge CLK);
        check("bp o_rdy_stall", 32'(bus.o_rdy), 32'd0);
        check_vec("bp stable o_if", bus.o_if, build(1, 1'b0));
        check_vec("bp stable o_w", bus.o_w, build(1, 1'b1));

        // Consume and transfer in the same cycle: no bubble.
        bus.i_rdy = 1'b1;
        @(negedge CLK);
        check("seamless o_vld", 32'(bus.o_vld), 32'd1);
        check("seamless o_rdy", 32'(bus.o_rdy), 32'd1);
        check_vec("seamless o_if", bus.o_if, build(2, 1'b0));
        check_vec("seamless o_w", bus.o_w, build(2, 1'b1));
        @(negedge CLK);
        check("seamless drain", 32'(bus.o_vld), 32'd0);
        wait_caps(2);
        if (cap_q.size() > 1) begin
            check_vec("order v1 o_if", cap_q[0].vif, build(1, 1'b0));
            check_vec("order v1 o_w", cap_q[0].vw, build(1, 1'b1));
            check_vec("order v2 o_if", cap_q[1].vif, build(2, 1'b0));
            check("order v2 o_lanes", 32'(cap_q[1].lanes), 32'(NDATA));
        end
        cap_q.delete();

        // Reset with one vector held and 30 pairs collected.
        bus.i_rdy = 1'b0;
        fill(0, NDATA, 1'b0);
        fill(1, 30, 1'b0);
        check("pre_reset o_vld", 32'(bus.o_vld), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_idle("midfill_reset");
        bus.i_rdy = 1'b1;
        fill(3, NDATA, 1'b0);
        wait_caps(1);
        if (cap_q.size() > 0) begin
            check("after_reset o_lanes", 32'(cap_q[0].lanes), 32'(NDATA));
            check_vec("after_reset o_if", cap_q[0].vif, build(3, 1'b0));
            check_vec("after_reset o_w", cap_q[0].vw, build(3, 1'b1));
        end
        cap_q.delete();

`ifdef PACKER_FLUSH_EN
        begin
            int fl_if[8] = '{4, 7, 2, 1, 7, 12, 1, 8};
            int fl_w[8]  = '{5, 1, 3, 0, 5, 1, 3, 0};
            logic [VW-1:0] e_if = '0;
            logic [VW-1:0] e_w  = '0;
            int sum = 0;
            for (int k = 0; k < 8; k++) begin
                e_if[k*NBIT +: NBIT] = NBIT'(fl_if[k]);
                e_w[k*NBIT +: NBIT]  = NBIT'(fl_w[k]);
                push(NBIT'(fl_if[k]), NBIT'(fl_w[k]), k == 7);
            end
            wait_caps(1);
            if (cap_q.size() > 0) begin
                check("flush o_lanes", 32'(cap_q[0].lanes), 32'd8);
                check_vec("flush o_if", cap_q[0].vif, e_if);
                check_vec("flush o_w", cap_q[0].vw, e_w);
                for (int k = 0; k < NDATA; k++) begin
                    logic signed [NBIT-1:0] a;
                    logic signed [NBIT-1:0] b;
                    int d;
                    a = cap_q[0].vif[k*NBIT +: NBIT];
                    b = cap_q[0].vw[k*NBIT +: NBIT];
                    d = int'(a) - int'(b);
                    sum += (d < 0) ? -d : d;
                end
                check("flush abs_sum", 32'(sum), 32'd32);
            end
            cap_q.delete();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule
